avalon_mem_test_master: RTL and testbench

Avalon-MM master that drives the other end of the on-chip memory slave interface. On a start pulse it fills a word range with a deterministic pattern, reads it back, and compares each word. It reports pass/fail, a saturating error count and the first failing address. It sits beside the Nios core on the same slave port and serves as a power-on/built-in memory self-test engine.

---
 rtl/avalon_mem_test_master.sv | 164 ++++++++++++++++
 tb/tb_avalon_mem_test_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mem_test_master.sv
// Avalon-MM memory self-test master: fills a word range with an additive pattern,
// reads it back one word at a time and reports pass/fail, error count and first failing address.
module avalon_mem_test_master #(
    parameter int          ADDR_W       = 10,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] PATTERN_STEP = 32'h9E3779B9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [31:0]       seed,
    input  logic              check_only,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       error_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic              avm_read,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);

    localparam logic [ADDR_W:0] FULL_RANGE = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE        = (ADDR_W+1)'(1);
    localparam logic [2:0]      LAT        = 3'(READ_LATENCY);

    typedef enum logic [2:0] {IDLE, WRITE, READ_REQ, READ_WAIT, FINISH} state_t;

    function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] wc);
        return (wc > FULL_RANGE) ? FULL_RANGE : wc;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t            state;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   idx;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       seed_q;
    logic [31:0]       pat;
    logic [2:0]        lat_cnt;
    logic              last_word;
    logic              mismatch;

    assign last_word      = (idx == count_q - ONE);
    assign mismatch       = (avm_readdata != pat);
    assign avm_byteenable = avm_chipselect ? 4'hF : 4'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            count_q        <= '0;
            idx            <= '0;
            base_q         <= '0;
            seed_q         <= '0;
            pat            <= '0;
            lat_cnt        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            error_count    <= '0;
            first_err_addr <= '0;
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            avm_read       <= 1'b0;
            avm_writedata  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q         <= base_addr;
                        seed_q         <= seed;
                        count_q        <= clamp_count(word_count);
                        idx            <= '0;
                        pat            <= seed;
                        error_count    <= '0;
                        pass           <= 1'b0;
                        first_err_addr <= '0;
                        busy           <= 1'b1;
                        avm_address    <= base_addr;
                        if (word_count == '0) begin
                            state <= FINISH;
                        end else if (check_only) begin
                            state          <= READ_REQ;
                            avm_chipselect <= 1'b1;
                            avm_read       <= 1'b1;
                        end else begin
                            state          <= WRITE;
                            avm_chipselect <= 1'b1;
                            avm_write      <= 1'b1;
                            avm_writedata  <= seed;
                        end
                    end
                end
                WRITE: begin
                    if (!avm_waitrequest) begin
                        if (last_word) begin
                            // Pattern restarts from seed for the read-back pass
                            idx           <= '0;
                            pat           <= seed_q;
                            avm_address   <= base_q;
                            avm_write     <= 1'b0;
                            avm_read      <= 1'b1;
                            avm_writedata <= '0;
                            state         <= READ_REQ;
                        end else begin
                            idx           <= idx + ONE;
                            pat           <= pat + PATTERN_STEP;
                            avm_address   <= avm_address + 1'b1;
                            avm_writedata <= pat + PATTERN_STEP;
                        end
                    end
                end
                READ_REQ: begin
                    if (!avm_waitrequest) begin
                        avm_chipselect <= 1'b0;
                        avm_read       <= 1'b0;
                        lat_cnt        <= 3'd1;
                        state          <= READ_WAIT;
                    end
                end
                READ_WAIT: begin
                    if (lat_cnt == LAT) begin
                        if (mismatch) begin
                            error_count <= sat_inc(error_count);
                            if (error_count == '0) first_err_addr <= avm_address;
                        end
                        if (last_word) begin
                            state <= FINISH;
                        end else begin
                            idx            <= idx + ONE;
                            pat            <= pat + PATTERN_STEP;
                            avm_address    <= avm_address + 1'b1;
                            avm_chipselect <= 1'b1;
                            avm_read       <= 1'b1;
                            state          <= READ_REQ;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (error_count == '0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_mem_test_master.sv
// Bench for avalon_mem_test_master: two builds (READ_LATENCY 1 and 3) share one RAM model
// with optional stalls and a bit-0 fault at word 5; results are predicted from the pattern rules.
module tb_avalon_mem_test_master;

    localparam int          AW   = 10;
    localparam logic [31:0] STEP = 32'h9E3779B9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic           m_start [2];
    logic [AW-1:0]  base_addr;
    logic [AW:0]    word_count;
    logic [31:0]    seed;
    logic           check_only;
    logic           m_busy [2], m_done [2], m_pass [2], m_cs [2], m_wr [2], m_rd [2];
    logic [15:0]    m_err [2];
    logic [AW-1:0]  m_ferr [2], m_addr [2];
    logic [3:0]     m_be [2];
    logic [31:0]    m_wdata [2];
    logic [31:0]    readdata;
    logic           waitrequest;

    avalon_mem_test_master #(.ADDR_W(AW), .READ_LATENCY(1)) u_dut (
        .clk(clk), .reset(reset), .start(m_start[0]), .base_addr(base_addr),
        .word_count(word_count), .seed(seed), .check_only(check_only),
        .busy(m_busy[0]), .done(m_done[0]), .pass(m_pass[0]), .error_count(m_err[0]),
        .first_err_addr(m_ferr[0]), .avm_address(m_addr[0]), .avm_byteenable(m_be[0]),
        .avm_chipselect(m_cs[0]), .avm_write(m_wr[0]), .avm_read(m_rd[0]),
        .avm_writedata(m_wdata[0]), .avm_readdata(readdata), .avm_waitrequest(waitrequest));

    avalon_mem_test_master #(.ADDR_W(AW), .READ_LATENCY(3)) u_dut_lat3 (
        .clk(clk), .reset(reset), .start(m_start[1]), .base_addr(base_addr),
        .word_count(word_count), .seed(seed), .check_only(check_only),
        .busy(m_busy[1]), .done(m_done[1]), .pass(m_pass[1]), .error_count(m_err[1]),
        .first_err_addr(m_ferr[1]), .avm_address(m_addr[1]), .avm_byteenable(m_be[1]),
        .avm_chipselect(m_cs[1]), .avm_write(m_wr[1]), .avm_read(m_rd[1]),
        .avm_writedata(m_wdata[1]), .avm_readdata(readdata), .avm_waitrequest(waitrequest));

    // RAM model: one build owns the bus at a time (sel)
    logic          sel, fault_en, stress;
    logic [AW-1:0] bus_addr;
    logic [31:0]   bus_wdata;
    logic          bus_cs, bus_wr, bus_rd;
    logic [31:0]   mem [1024];
    logic [31:0]   model_mem [1024];
    logic          pv [1:3];
    logic [31:0]   pd [1:3];
    int            stall_left;
    logic          stalled;
    logic [44:0]   snap;
    logic [41:0]   wr_log [$];
    logic [9:0]    rd_log [$];
    int            bus_viol = 0, stall_viol = 0;

    always_comb begin
        bus_addr  = m_addr[sel];
        bus_wdata = m_wdata[sel];
        bus_cs    = m_cs[sel];
        bus_wr    = m_wr[sel];
        bus_rd    = m_rd[sel];
    end

    always_comb waitrequest = stress && bus_cs && (stall_left != 0);
    // Data is only valid in exactly the cycle READ_LATENCY after accept
    always_comb readdata = (sel ? pv[3] : pv[1]) ? (sel ? pd[3] : pd[1]) : 32'hDEADBEEF;

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= 3; k++) pv[k] <= 1'b0;
            for (int a = 0; a < 1024; a++) mem[a] <= 32'h0;
            stall_left <= 0;
            stalled    <= 1'b0;
        end else begin
            pv[1] <= bus_cs && bus_rd && !waitrequest;
            pd[1] <= mem[bus_addr] ^ {31'd0, fault_en && (bus_addr == 10'h005)};
            pv[2] <= pv[1];  pd[2] <= pd[1];
            pv[3] <= pv[2];  pd[3] <= pd[2];
            if (bus_cs && !waitrequest) begin
                if (bus_wr) begin
                    mem[bus_addr] <= bus_wdata;
                    wr_log.push_back({bus_addr, bus_wdata});
                end
                if (bus_rd) rd_log.push_back(bus_addr);
                stall_left <= $urandom_range(0, 3);
            end else if (waitrequest) begin
                stall_left <= stall_left - 1;
            end
            stalled <= waitrequest;
            snap    <= {bus_addr, bus_wdata, bus_cs, bus_wr, bus_rd};
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            for (int g = 0; g < 2; g++)
                if ((m_wr[g] && m_rd[g]) || (m_cs[g] != (m_wr[g] || m_rd[g])) ||
                    (m_be[g] != (m_cs[g] ? 4'hF : 4'h0)))
                    bus_viol = bus_viol + 1;
            if (stalled && (snap != {bus_addr, bus_wdata, bus_cs, bus_wr, bus_rd}))
                stall_viol = stall_viol + 1;
        end
    end

    int n_checks = 0, n_pass = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    typedef struct {
        logic [9:0]  base;
        logic [10:0] count;
        logic [31:0] seed;
        logic        chk, fault, stress, sel, poke, use_tab, exp_pass;
        int          exp_err;
        logic [9:0]  exp_first;
        int          exp_cyc;
    } vec_t;

    function automatic vec_t mk(logic [9:0] b, logic [10:0] c, logic [31:0] s, logic chk,
                                logic flt, logic st, logic sl, logic pk, logic ep, int ee,
                                logic [9:0] ef, int ec);
        vec_t v;
        v.base = b; v.count = c; v.seed = s; v.chk = chk; v.fault = flt; v.stress = st;
        v.sel = sl; v.poke = pk; v.use_tab = 1'b1; v.exp_pass = ep; v.exp_err = ee;
        v.exp_first = ef; v.exp_cyc = ec;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int n, lat, cyc, exp_cyc, errs, w0, r0, bv0, sv0;
        logic [9:0]  a, first;
        logic [31:0] p, got;
        logic        found, got_done;
        logic [41:0] exp_w [$];
        logic [9:0]  exp_r [$];
        n   = (v.count > 11'd1024) ? 1024 : int'(v.count);
        lat = v.sel ? 3 : 1;
        sel = v.sel; fault_en = v.fault; stress = v.stress;
        for (int k = 0; k < 1024; k++) model_mem[k] = mem[k];
        errs = 0; found = 1'b0; first = '0;
        if (!v.chk)
            for (int i = 0; i < n; i++) begin
                a = v.base + 10'(i);
                p = v.seed + 32'(i) * STEP;
                model_mem[a] = p;
                exp_w.push_back({a, p});
            end
        for (int i = 0; i < n; i++) begin
            a = v.base + 10'(i);
            p = v.seed + 32'(i) * STEP;
            exp_r.push_back(a);
            got = model_mem[a] ^ ((v.fault && a == 10'h005) ? 32'h1 : 32'h0);
            if (got != p) begin
                if (!found) first = a;
                found = 1'b1;
                if (errs < 65535) errs++;
            end
        end
        exp_cyc = (n == 0) ? 2 : (v.chk ? 0 : n) + n * (1 + lat) + 2;
        w0 = wr_log.size(); r0 = rd_log.size(); bv0 = bus_viol; sv0 = stall_viol;

        @(negedge clk);
        base_addr = v.base; word_count = v.count; seed = v.seed; check_only = v.chk;
        m_start[v.sel] = 1'b1;
        cyc = 0; got_done = 1'b0;
        while (!got_done && cyc < 5000) begin
            @(posedge clk);
            @(negedge clk);
            m_start[0] = 1'b0; m_start[1] = 1'b0;
            cyc++;
            if (m_done[v.sel]) got_done = 1'b1;
            else if (v.poke && cyc == 5) begin
                check({tag, "_busy_at_poke"}, m_busy[v.sel], 1);
                base_addr = '0; word_count = 11'd1; seed = '0; check_only = 1'b1;
                m_start[v.sel] = 1'b1;
            end
        end
        check({tag, "_done_seen"}, got_done, 1);
        if (!v.stress) check({tag, "_latency"}, cyc, exp_cyc);
        check({tag, "_pass"}, m_pass[v.sel], !found);
        check({tag, "_err_count"}, m_err[v.sel], errs);
        check({tag, "_first_err"}, m_ferr[v.sel], first);
        if (v.use_tab) begin
            if (v.exp_cyc >= 0) check({tag, "_latency_tab"}, cyc, v.exp_cyc);
            check({tag, "_pass_tab"}, m_pass[v.sel], v.exp_pass);
            check({tag, "_err_tab"}, m_err[v.sel], v.exp_err);
            check({tag, "_first_tab"}, m_ferr[v.sel], v.exp_first);
        end
        check({tag, "_busy_at_done"}, m_busy[v.sel], 0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, m_done[v.sel], 0);
        check({tag, "_wr_beats"}, wr_log.size() - w0, exp_w.size());
        for (int i = 0; i < exp_w.size() && w0 + i < wr_log.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), wr_log[w0 + i], exp_w[i]);
        check({tag, "_rd_beats"}, rd_log.size() - r0, exp_r.size());
        for (int i = 0; i < exp_r.size() && r0 + i < rd_log.size(); i++)
            check($sformatf("%s_rd%0d", tag, i), rd_log[r0 + i], exp_r[i]);
        check({tag, "_bus_rules"}, bus_viol - bv0, 0);
        check({tag, "_stall_hold"}, stall_viol - sv0, 0);
    endtask

    vec_t tab [12];

    initial begin
        vec_t v;
        int   t, w0;
        tab[0]  = mk(10'h3FE, 11'd4,     32'h00000001, 0, 0, 0, 0, 0, 1, 0, 10'h000, 14);
        tab[1]  = mk(10'h000, 11'd16,    32'h12345678, 0, 1, 0, 0, 0, 0, 1, 10'h005, 50);
        tab[2]  = mk(10'h3FE, 11'd4,     32'h00000001, 0, 0, 1, 0, 0, 1, 0, 10'h000, -1);
        tab[3]  = mk(10'h000, 11'd16,    32'h12345678, 0, 1, 1, 0, 0, 0, 1, 10'h005, -1);
        tab[4]  = mk(10'h100, 11'd8,     32'hA5A5A5A5, 0, 0, 0, 0, 0, 1, 0, 10'h000, 26);
        tab[5]  = mk(10'h100, 11'd8,     32'hA5A5A5A5, 1, 0, 0, 0, 0, 1, 0, 10'h000, 18);
        tab[6]  = mk(10'h100, 11'd8,     32'h00000000, 1, 0, 0, 0, 0, 0, 8, 10'h100, 18);
        tab[7]  = mk(10'h055, 11'd0,     32'h11111111, 0, 0, 0, 0, 0, 1, 0, 10'h000, 2);
        tab[8]  = mk(10'h020, 11'd5,     32'hCAFEF00D, 0, 0, 0, 1, 0, 1, 0, 10'h000, 27);
        tab[9]  = mk(10'h020, 11'd5,     32'hCAFEF00D, 1, 0, 0, 1, 0, 1, 0, 10'h000, 22);
        tab[10] = mk(10'h300, 11'd10,    32'h13579BDF, 0, 0, 0, 0, 1, 1, 0, 10'h000, 32);
        tab[11] = mk(10'h200, 11'h7FF,   32'h0BADF00D, 0, 0, 0, 0, 0, 1, 0, 10'h000, 3074);

        reset = 1'b1; m_start[0] = 1'b0; m_start[1] = 1'b0;
        base_addr = '0; word_count = '0; seed = '0; check_only = 1'b0;
        sel = 1'b0; fault_en = 1'b0; stress = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("reset_status%0d", g),
                  {m_busy[g], m_done[g], m_pass[g], m_err[g], m_ferr[g]}, 0);
            check($sformatf("reset_bus%0d", g),
                  {m_addr[g], m_be[g], m_cs[g], m_wr[g], m_rd[g], m_wdata[g]}, 0);
        end
        reset = 1'b0;

        for (int k = 0; k < 12; k++) run_vec(tab[k], $sformatf("vec%0d", k));

        for (int r = 0; r < 8; r++) begin
            v.base = 10'($urandom); v.count = 11'($urandom_range(0, 40)); v.seed = $urandom;
            v.chk = ($urandom_range(0, 3) == 0); v.fault = 1'($urandom_range(0, 1));
            v.stress = 1'($urandom_range(0, 1)); v.sel = 1'($urandom_range(0, 1));
            v.poke = 1'b0; v.use_tab = 1'b0; v.exp_pass = 1'b0; v.exp_err = 0;
            v.exp_first = '0; v.exp_cyc = -1;
            run_vec(v, $sformatf("rnd%0d", r));
        end

        // Reset asserted mid-fill: outputs must clear before the next clock edge
        sel = 1'b0; fault_en = 1'b0; stress = 1'b0;
        w0 = wr_log.size();
        @(negedge clk);
        base_addr = '0; word_count = 11'd10; seed = 32'h00000077; check_only = 1'b0;
        m_start[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_start[0] = 1'b0;
        t = 0;
        while (wr_log.size() - w0 < 3 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("rst_reached_write", (t < 50) && m_wr[0], 1);
        #1 reset = 1'b1;
        #1;
        check("async_rst_bus", {m_addr[0], m_be[0], m_cs[0], m_wr[0], m_rd[0]}, 0);
        check("async_rst_status",
              {m_busy[0], m_done[0], m_pass[0], m_err[0], m_ferr[0], m_wdata[0]}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_no_done", {m_done[0], m_busy[0]}, 0);
        run_vec(mk(10'h000, 11'd10, 32'h00000077, 0, 0, 0, 0, 0, 1, 0, 10'h000, 32), "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
